// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module  : branch_resolve_unit
// Brief   : Pipelined branch / jump / add resolution with misprediction detect,
//           valid/ready handshakes on both sides and a global kill.
// Revision: 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
    parameter int WIDTH  = 32,
    parameter int TAG_W  = 4,
    parameter int STAGES = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_op,
    input  logic [2:0]       i_func,
    input  logic [WIDTH-1:0] i_rs1,
    input  logic [WIDTH-1:0] i_rs2,
    input  logic [WIDTH-1:0] i_imm,
    input  logic [WIDTH-1:0] i_pc,
    input  logic             i_pred_taken,
    input  logic [WIDTH-1:0] i_pred_target,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_kill,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_taken,
    output logic             o_mispredict,
    output logic [WIDTH-1:0] o_redirect,
    output logic [TAG_W-1:0] o_tag
);

    typedef struct packed {
        logic [2:0]       op;
        logic [2:0]       func;
        logic [WIDTH-1:0] rs1;
        logic [WIDTH-1:0] rs2;
        logic [WIDTH-1:0] imm;
        logic [WIDTH-1:0] pc;
        logic             pred_taken;
        logic [WIDTH-1:0] pred_target;
        logic [TAG_W-1:0] tag;
    } op_t;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             taken;
        logic             mispredict;
        logic [WIDTH-1:0] redirect;
        logic [TAG_W-1:0] tag;
    } res_t;

    localparam logic [2:0] OP_BR    = 3'd0;
    localparam logic [2:0] OP_JAL   = 3'd1;
    localparam logic [2:0] OP_JALR  = 3'd2;
    localparam logic [2:0] OP_AUIPC = 3'd3;
    localparam logic [2:0] OP_LUI   = 3'd5;
    localparam logic [WIDTH-1:0] JALR_MASK = {{(WIDTH-1){1'b1}}, 1'b0};

    // Reserved opcodes fall through to the default arm, which is ADDI.
    function automatic res_t resolve(input op_t o);
        logic             eq;
        logic             lt;
        logic             ltu;
        logic             cond;
        logic             taken;
        logic [WIDTH-1:0] seq;
        logic [WIDTH-1:0] target;
        logic [WIDTH-1:0] result;
        res_t             r;
        eq     = (o.rs1 == o.rs2);
        lt     = ($signed(o.rs1) < $signed(o.rs2));
        ltu    = (o.rs1 < o.rs2);
        cond   = (o.func[2] ? (o.func[1] ? ltu : lt) : eq) ^ o.func[0];
        seq    = o.pc + WIDTH'(4);
        taken  = 1'b0;
        target = o.pc + o.imm;
        result = o.rs1 + o.imm;
        case (o.op)
            OP_BR: begin
                taken  = cond;
                result = '0;
            end
            OP_JAL: begin
                taken  = 1'b1;
                result = seq;
            end
            OP_JALR: begin
                taken  = 1'b1;
                target = (o.rs1 + o.imm) & JALR_MASK;
                result = seq;
            end
            OP_AUIPC: result = o.pc + o.imm;
            OP_LUI:   result = o.imm;
            default:  ;
        endcase
        r.result     = result;
        r.taken      = taken;
        r.mispredict = (taken != o.pred_taken) || (taken && (o.pred_target != target));
        r.redirect   = taken ? target : seq;
        r.tag        = o.tag;
        return r;
    endfunction

    op_t  in_op;
    logic feed_valid;
    res_t feed;
    logic out_valid;
    res_t out;
    logic out_adv;

    assign in_op.op          = i_op;
    assign in_op.func        = i_func;
    assign in_op.rs1         = i_rs1;
    assign in_op.rs2         = i_rs2;
    assign in_op.imm         = i_imm;
    assign in_op.pc          = i_pc;
    assign in_op.pred_taken  = i_pred_taken;
    assign in_op.pred_target = i_pred_target;
    assign in_op.tag         = i_tag;

    assign out_adv = !out_valid || i_ready;

    generate
        if (STAGES == 2) begin : g_two_stage
            logic s1_valid;
            op_t  s1;
            logic s1_adv;

            assign s1_adv  = !s1_valid || out_adv;
            assign o_ready = !i_kill && s1_adv;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    s1_valid <= 1'b0;
                    s1       <= '0;
                end else if (i_kill) begin
                    s1_valid <= 1'b0;
                end else if (s1_adv) begin
                    s1_valid <= i_valid;
                    if (i_valid) begin
                        s1 <= in_op;
                    end
                end
            end

            assign feed_valid = s1_valid;
            assign feed       = resolve(s1);
        end else begin : g_one_stage
            assign o_ready    = !i_kill && out_adv;
            assign feed_valid = i_valid;
            assign feed       = resolve(in_op);
        end
    endgenerate

    // Payload only loads alongside a valid op, so a stalled result stays frozen.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_valid <= 1'b0;
            out       <= '0;
        end else if (i_kill) begin
            out_valid <= 1'b0;
        end else if (out_adv) begin
            out_valid <= feed_valid;
            if (feed_valid) begin
                out <= feed;
            end
        end
    end

    assign o_valid      = out_valid;
    assign o_result     = out.result;
    assign o_taken      = out.taken;
    assign o_mispredict = out.mispredict;
    assign o_redirect   = out.redirect;
    assign o_tag        = out.tag;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_branch_resolve_unit
// Brief   : Scoreboard bench for branch_resolve_unit (two-stage configuration).
// Revision: 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

    localparam int STG = 2;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [2:0]  i_op;
    logic [2:0]  i_func;
    logic [31:0] i_rs1;
    logic [31:0] i_rs2;
    logic [31:0] i_imm;
    logic [31:0] i_pc;
    logic        i_pred_taken;
    logic [31:0] i_pred_target;
    logic [3:0]  i_tag;
    logic        i_kill;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic        o_taken;
    logic        o_mispredict;
    logic [31:0] o_redirect;
    logic [3:0]  o_tag;

    typedef struct packed {
        logic [31:0] result;
        logic        taken;
        logic        misp;
        logic [31:0] redirect;
        logic [3:0]  tag;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   errors    = 0;
    int   delivered = 0;
    bit   rnd_done  = 0;

    branch_resolve_unit #(.WIDTH(32), .TAG_W(4), .STAGES(STG)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_op(i_op), .i_func(i_func), .i_rs1(i_rs1), .i_rs2(i_rs2),
        .i_imm(i_imm), .i_pc(i_pc), .i_pred_taken(i_pred_taken),
        .i_pred_target(i_pred_target), .i_tag(i_tag), .i_kill(i_kill),
        .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
        .o_taken(o_taken), .o_mispredict(o_mispredict),
        .o_redirect(o_redirect), .o_tag(o_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] res, input logic tk, input logic mp,
                                input logic [31:0] rd, input logic [3:0] tg);
        exp_t e;
        e.result = res; e.taken = tk; e.misp = mp; e.redirect = rd; e.tag = tg;
        return e;
    endfunction

    function automatic exp_t model(input logic [2:0] op, input logic [2:0] f,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] imm, input logic [31:0] pc,
                                   input logic pt, input logic [31:0] ptgt,
                                   input logic [3:0] tag);
        logic        c;
        logic [31:0] tgt;
        exp_t        e;
        case (f)
            3'b000, 3'b010: c = (a == b);
            3'b001, 3'b011: c = (a != b);
            3'b100:         c = $signed(a) <  $signed(b);
            3'b101:         c = $signed(a) >= $signed(b);
            3'b110:         c = a <  b;
            default:        c = a >= b;
        endcase
        e = '0;
        e.tag = tag;
        tgt = pc + imm;
        case (op)
            3'd0: e.taken = c;
            3'd1: begin e.taken = 1'b1; e.result = pc + 32'd4; end
            3'd2: begin e.taken = 1'b1; tgt = a + imm; tgt[0] = 1'b0; e.result = pc + 32'd4; end
            3'd3: e.result = pc + imm;
            3'd5: e.result = imm;
            default: e.result = a + imm;
        endcase
        e.redirect = e.taken ? tgt : pc + 32'd4;
        e.misp = (e.taken != pt) || (e.taken && ptgt != tgt);
        return e;
    endfunction

    task automatic drive(input logic [2:0] op, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc,
                         input logic pt, input logic [31:0] ptgt, input logic [3:0] tag);
        i_op = op; i_func = f; i_rs1 = a; i_rs2 = b; i_imm = imm; i_pc = pc;
        i_pred_taken = pt; i_pred_target = ptgt; i_tag = tag;
    endtask

    // Offer one op and push its expectation when the handshake is seen.
    task automatic send(input logic [2:0] op, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc,
                        input logic pt, input logic [31:0] ptgt, input logic [3:0] tag,
                        input exp_t e);
        drive(op, f, a, b, imm, pc, pt, ptgt, tag);
        i_valid = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (o_ready) begin
                sb.push_back(e);
                @(posedge clk);
                #1;
                i_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        check("accept_timeout", 0, 1);
        i_valid = 1'b0;
    endtask

    task automatic send_m(input logic [2:0] op, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc,
                          input logic pt, input logic [31:0] ptgt, input logic [3:0] tag);
        send(op, f, a, b, imm, pc, pt, ptgt, tag, model(op, f, a, b, imm, pc, pt, ptgt, tag));
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && sb.size() != 0; n++) @(posedge clk);
        #1;
        check("drain_empty", sb.size(), 0);
    endtask

    // Output monitor: scoreboard compare on handshake, hold check on stall.
    logic [69:0] prev_snap;
    bit          prev_stall = 0;
    always @(negedge clk) begin
        exp_t e;
        logic [69:0] snap;
        snap = {o_result, o_taken, o_mispredict, o_redirect, o_tag};
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall && o_valid) check("hold_stable", snap, prev_snap);
            if (o_valid && i_ready && !i_kill) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("result",   o_result,     e.result);
                    check("taken",    o_taken,      e.taken);
                    check("mispred",  o_mispredict, e.misp);
                    check("redirect", o_redirect,   e.redirect);
                    check("tag",      o_tag,        e.tag);
                end
                delivered++;
            end
            prev_stall = o_valid && !i_ready && !i_kill;
            prev_snap  = snap;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int base;
        rst = 1'b1; i_valid = 1'b0; i_kill = 1'b0; i_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", o_valid, 0);
        check("rst_taken", o_taken, 0);
        check("rst_misp",  o_mispredict, 0);
        check("rst_fields", {o_result, o_redirect, o_tag}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // BEQ taken, predicted not-taken; latency check
        send(3'd0, 3'b000, 5, 5, 32'h20, 32'h100, 0, 0, 4'h1, mk(0, 1, 1, 32'h120, 4'h1));
        check("lat_early", o_valid, 0);
        @(posedge clk);
        #1;
        check("lat_valid", o_valid, 1);
        drain();

        send(3'd0, 3'b110, 32'hFFFFFFFF, 1, 32'h10, 32'h200, 0, 0, 4'h2, mk(0, 0, 0, 32'h204, 4'h2));
        send(3'd0, 3'b100, 32'hFFFFFFFF, 1, 32'h10, 32'h200, 0, 0, 4'h3, mk(0, 1, 1, 32'h210, 4'h3));
        send(3'd2, 3'b000, 32'h1003, 0, 0, 32'h40, 1, 32'h1002, 4'h4, mk(32'h44, 1, 0, 32'h1002, 4'h4));
        send(3'd2, 3'b000, 32'h1003, 0, 0, 32'h40, 1, 32'h1000, 4'h5, mk(32'h44, 1, 1, 32'h1002, 4'h5));
        send(3'd3, 3'b000, 0, 0, 32'h20, 32'hFFFFFFF0, 0, 0, 4'h6, mk(32'h10, 0, 0, 32'hFFFFFFF4, 4'h6));
        send(3'd5, 3'b000, 0, 0, 32'hABCDE000, 32'h300, 0, 0, 4'h7, mk(32'hABCDE000, 0, 0, 32'h304, 4'h7));
        send(3'd4, 3'b000, 10, 0, 32'hFFFFFFFD, 32'h80, 1, 32'h999, 4'h8, mk(7, 0, 1, 32'h84, 4'h8));
        send(3'd7, 3'b000, 32'h100, 0, 32'h11, 32'h90, 0, 0, 4'h9, mk(32'h111, 0, 0, 32'h94, 4'h9));
        send(3'd1, 3'b000, 0, 0, 32'hFFFFFF00, 32'h1000, 1, 32'hF00, 4'hA, mk(32'h1004, 1, 0, 32'hF00, 4'hA));
        send(3'd0, 3'b111, 3, 3, 32'h8, 32'h500, 1, 32'h508, 4'hB, mk(0, 1, 0, 32'h508, 4'hB));
        drain();

        // Four back-to-back ops against a stalled consumer
        base = delivered;
        i_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 4; k++)
                    send_m(3'd4, 3'b000, 32'h1000 * (k + 1), 0, k, 32'h600 + 4 * k, 0, 0, 4'(k + 1));
            end
            begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                check("stall_ready_low", o_ready, 0);
                check("stall_head_tag", o_tag, 4'h1);
                @(posedge clk);
                #1;
                i_ready = 1'b1;
            end
        join
        drain();
        check("stall_count", delivered - base, 4);

        // Kill with two in flight and a third offered
        i_ready = 1'b0;
        send_m(3'd4, 3'b000, 1, 0, 1, 32'h700, 0, 0, 4'hC);
        send_m(3'd4, 3'b000, 2, 0, 2, 32'h704, 0, 0, 4'hD);
        drive(3'd4, 3'b000, 3, 0, 3, 32'h708, 0, 0, 4'hE);
        i_valid = 1'b1;
        i_kill  = 1'b1;
        @(negedge clk);
        check("kill_ready", o_ready, 0);
        sb.delete();
        @(posedge clk);
        #1;
        i_kill = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        check("kill_valid", o_valid, 0);
        base = delivered;
        repeat (4) @(posedge clk);
        #1;
        check("kill_none_out", delivered - base, 0);
        send_m(3'd1, 3'b000, 0, 0, 32'h40, 32'h800, 1, 32'h840, 4'hF);
        drain();
        check("post_kill_count", delivered - base, 1);

        // Asynchronous reset mid-stream
        i_ready = 1'b0;
        send_m(3'd4, 3'b000, 5, 0, 5, 32'h900, 0, 0, 4'h3);
        send_m(3'd4, 3'b000, 6, 0, 6, 32'h904, 0, 0, 4'h4);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("arst_valid", o_valid, 0);
        check("arst_fields", {o_result, o_taken, o_mispredict, o_redirect, o_tag}, 0);
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        check("arst_after", o_valid, 0);

        // Random traffic with a randomly stalling consumer
        fork
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    i_ready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int k = 0; k < 30; k++) begin
            logic [2:0]  op;
            logic [31:0] a, b, imm, pc, tgt;
            logic        pt;
            op  = 3'($urandom_range(0, 7));
            a   = $urandom();
            b   = ($urandom_range(0, 1) == 1) ? a : $urandom();
            imm = $urandom();
            pc  = $urandom();
            pt  = 1'($urandom_range(0, 1));
            tgt = ($urandom_range(0, 1) == 1) ? pc + imm : $urandom();
            send_m(op, 3'($urandom_range(0, 7)), a, b, imm, pc, pt, tgt, 4'(k));
        end
        rnd_done = 1;
        @(posedge clk);
        #2;
        i_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
